// File: rtl/debug_trace_pkg.sv
// Shared trace entry type and slot-liveness rule for the debug trace serializer.
package debug_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_entry_t;

  // A slot that writes nothing (no byte enables or r0) is invisible to the golden trace.
  function automatic logic trace_live(input trace_entry_t entry,
                                      input logic         valid,
                                      input logic         drop_no_write);
    logic live;
    live = valid;
    if (drop_no_write && ((entry.wen == 4'd0) || (entry.wnum == 5'd0)))
      live = 1'b0;
    return live;
  endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Trace buffer with two ordered write ports and one read port; wr1 is only used together with wr0.
// head_next is the entry that will sit at the head after this cycle's read and writes.
module trace_fifo_2w1r
  import debug_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr0_en,
  input  trace_entry_t             wr0_data,
  input  logic                     wr1_en,
  input  trace_entry_t             wr1_data,
  input  logic                     rd_en,
  output logic [$clog2(DEPTH):0]   count,
  output trace_entry_t             head_next,
  output logic                     head_next_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr1;
  logic [AW-1:0]   wr_ptr1;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   rem;
  logic [1:0]      n_wr;

  assign rd_ptr1 = rd_ptr + AW'(1);
  assign wr_ptr1 = wr_ptr + AW'(1);
  assign n_wr    = {1'b0, wr0_en} + {1'b0, wr1_en};
  assign rem     = cnt - CW'(rd_en);
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr_ptr]  <= wr0_data;
    if (wr1_en) mem[wr_ptr1] <= wr1_data;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(rd_en);
      wr_ptr <= wr_ptr + AW'(n_wr);
      cnt    <= rem + CW'(n_wr);
    end
  end

  always_comb begin
    head_next       = mem[rd_ptr];
    head_next_valid = 1'b0;
    if (rem != '0) begin
      head_next       = rd_en ? mem[rd_ptr1] : mem[rd_ptr];
      head_next_valid = 1'b1;
    end else if (wr0_en) begin
      head_next       = wr0_data;
      head_next_valid = 1'b1;
    end
  end

endmodule

// File: rtl/debug_trace_serializer.sv
// Serializes up to two retired instructions per cycle into the single-issue debug trace, oldest first.
// Entry pushed at N is shown at N+1; retire_stall asks writeback to hold once the buffer nears full.
module debug_trace_serializer
  import debug_trace_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter bit DROP_NO_WRITE = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  wb_rf_wen,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [4:0]  wb_rf_wnum,
  input  logic [31:0] wb_rf_wdata,
  input  logic        wb1_valid,
  input  logic [31:0] wb1_pc,
  input  logic [3:0]  wb1_rf_wen,
  input  logic [4:0]  wb1_rf_wnum,
  input  logic [31:0] wb1_rf_wdata,
  input  logic        wb1_first,
  input  logic        out_ready,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic        out_valid,
  output logic        retire_stall,
  output logic        overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  trace_entry_t  e0, e1, push0, push1, head_next, out_q;
  logic          live0, live1, head_next_valid, pop;
  logic          acc0, acc1, lost;
  logic [1:0]    n_live;
  logic [CW-1:0] count, space;
  logic          overflow_q;

  assign e0 = '{pc: wb_pc,  wen: wb_rf_wen,  wnum: wb_rf_wnum,  wdata: wb_rf_wdata};
  assign e1 = '{pc: wb1_pc, wen: wb1_rf_wen, wnum: wb1_rf_wnum, wdata: wb1_rf_wdata};

  assign live0 = trace_live(e0, wb_valid,  DROP_NO_WRITE);
  assign live1 = trace_live(e1, wb1_valid, DROP_NO_WRITE);

  // Compact live slots onto push0/push1, older first; a lone slot always goes to push0.
  always_comb begin
    push0  = e0;
    push1  = e1;
    n_live = 2'd0;
    if (live0 && live1) begin
      n_live = 2'd2;
      if (wb1_first) begin
        push0 = e1;
        push1 = e0;
      end
    end else if (live0) begin
      n_live = 2'd1;
      push0  = e0;
    end else if (live1) begin
      n_live = 2'd1;
      push0  = e1;
    end
  end

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign space     = CW'(DEPTH) - count + CW'(pop);
  assign acc0      = (n_live != 2'd0) && (space != '0);
  assign acc1      = (n_live == 2'd2) && (space >= CW'(2));
  assign lost      = CW'(n_live) > space;

  trace_fifo_2w1r #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk             (clk),
    .resetn          (resetn),
    .wr0_en          (acc0),
    .wr0_data        (push0),
    .wr1_en          (acc1),
    .wr1_data        (push1),
    .rd_en           (pop),
    .count           (count),
    .head_next       (head_next),
    .head_next_valid (head_next_valid)
  );

  // Output register mirrors the buffer head; it only loads when an entry will be presented,
  // so pc/wnum/wdata keep their last value while the buffer is empty.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (head_next_valid) out_q <= head_next;
      if (lost) overflow_q <= 1'b1;
    end
  end

  assign debug_wb_pc       = out_q.pc;
  assign debug_wb_rf_wen   = out_valid ? out_q.wen : 4'd0;
  assign debug_wb_rf_wnum  = out_q.wnum;
  assign debug_wb_rf_wdata = out_q.wdata;
  assign retire_stall      = count >= CW'(DEPTH - 2);
  assign overflow          = overflow_q;

endmodule
